// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline register: DEPTH valid/ready slots; empty slots always carry a zero control field.
// Optional STALL_COUNT_EN macro adds saturating stall/bubble cycle counters.
module pipe_stage_elastic #(
  parameter int DATA_W = 138,
  parameter int CTRL_W = 10,
  parameter int DEPTH  = 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [15:0]       stall_cnt,
  output logic [15:0]       bubble_cnt
);

  logic [DEPTH-1:0]  valid_q;
  logic [CTRL_W-1:0] ctrl_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];

  logic [DEPTH-1:0]  adv;
  logic [DEPTH-1:0]  src_valid;
  logic [CTRL_W-1:0] src_ctrl [DEPTH];
  logic [DATA_W-1:0] src_data [DEPTH];

  // A slot may advance when the output drains or any slot at or beyond it is empty.
  always_comb begin
    adv = '0;
    for (int i = 0; i < DEPTH; i++) begin
      adv[i] = out_ready;
      for (int j = i; j < DEPTH; j++) begin
        if (!valid_q[j]) adv[i] = 1'b1;
      end
    end
  end

  always_comb begin
    src_valid   = '0;
    src_valid[0] = in_valid;
    src_ctrl[0]  = in_ctrl;
    src_data[0]  = in_data;
    for (int i = 1; i < DEPTH; i++) begin
      src_valid[i] = valid_q[i-1];
      src_ctrl[i]  = ctrl_q[i-1];
      src_data[i]  = data_q[i-1];
    end
  end

  genvar g;
  generate
    for (g = 0; g < DEPTH; g++) begin : g_slot
      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          valid_q[g] <= 1'b0;
          ctrl_q[g]  <= '0;
          data_q[g]  <= '0;
        end else if (flush) begin
          valid_q[g] <= 1'b0;
          ctrl_q[g]  <= '0;
        end else if (adv[g]) begin
          valid_q[g] <= src_valid[g];
          if (src_valid[g]) begin
            ctrl_q[g] <= src_ctrl[g];
            data_q[g] <= src_data[g];
          end else begin
            ctrl_q[g] <= '0;
          end
        end
      end
    end
  endgenerate

  assign in_ready  = adv[0] & ~flush;
  assign out_valid = valid_q[DEPTH-1];
  assign out_data  = data_q[DEPTH-1];
  assign out_ctrl  = ctrl_q[DEPTH-1];

`ifdef STALL_COUNT_EN
  logic [15:0] stall_q;
  logic [15:0] bubble_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stall_q  <= '0;
      bubble_q <= '0;
    end else begin
      if (out_valid && !out_ready && stall_q != 16'hFFFF) stall_q <= stall_q + 16'd1;
      if (!out_valid && bubble_q != 16'hFFFF) bubble_q <= bubble_q + 16'd1;
    end
  end

  assign stall_cnt  = stall_q;
  assign bubble_cnt = bubble_q;
`else
  assign stall_cnt  = 16'h0000;
  assign bubble_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Directed bench for pipe_stage_elastic: three instances at DEPTH 1, 2 and 3.
module tb_pipe_stage_elastic;
  localparam int DATA_W = 138;
  localparam int CTRL_W = 10;
`ifdef STALL_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  bit cnt_en = CNT_EN;

  logic a_in_valid = 0, a_in_ready, a_flush = 0, a_out_valid, a_out_ready = 0;
  logic [DATA_W-1:0] a_in_data = '0, a_out_data;
  logic [CTRL_W-1:0] a_in_ctrl = '0, a_out_ctrl;
  logic [15:0] a_stall_cnt, a_bubble_cnt;

  logic b_in_valid = 0, b_in_ready, b_flush = 0, b_out_valid, b_out_ready = 0;
  logic [DATA_W-1:0] b_in_data = '0, b_out_data;
  logic [CTRL_W-1:0] b_in_ctrl = '0, b_out_ctrl;
  logic [15:0] b_stall_cnt, b_bubble_cnt;

  logic c_in_valid = 0, c_in_ready, c_flush = 0, c_out_valid, c_out_ready = 0;
  logic [DATA_W-1:0] c_in_data = '0, c_out_data;
  logic [CTRL_W-1:0] c_in_ctrl = '0, c_out_ctrl;
  logic [15:0] c_stall_cnt, c_bubble_cnt;

  pipe_stage_elastic #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .DEPTH(1)) u_a (
    .clock(clock), .reset_n(reset_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_data(a_in_data), .in_ctrl(a_in_ctrl), .flush(a_flush), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .out_data(a_out_data), .out_ctrl(a_out_ctrl),
    .stall_cnt(a_stall_cnt), .bubble_cnt(a_bubble_cnt));

  pipe_stage_elastic #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .DEPTH(2)) u_b (
    .clock(clock), .reset_n(reset_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .in_ctrl(b_in_ctrl), .flush(b_flush), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .out_data(b_out_data), .out_ctrl(b_out_ctrl),
    .stall_cnt(b_stall_cnt), .bubble_cnt(b_bubble_cnt));

  pipe_stage_elastic #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .DEPTH(3)) u_c (
    .clock(clock), .reset_n(reset_n), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .in_data(c_in_data), .in_ctrl(c_in_ctrl), .flush(c_flush), .out_valid(c_out_valid),
    .out_ready(c_out_ready), .out_data(c_out_data), .out_ctrl(c_out_ctrl),
    .stall_cnt(c_stall_cnt), .bubble_cnt(c_bubble_cnt));

  task automatic test_reset();
    @(negedge clock);
    checks++;
    if (a_out_valid !== 1'b0 || a_out_ctrl !== '0 || a_out_data !== '0) begin
      errors++; $display("FAIL reset_a: valid=%b ctrl=%h data=%h, want all 0", a_out_valid, a_out_ctrl, a_out_data);
    end
    checks++;
    if (c_out_valid !== 1'b0 || c_out_ctrl !== '0 || c_stall_cnt !== 16'h0 || c_bubble_cnt !== 16'h0) begin
      errors++; $display("FAIL reset_c: valid=%b ctrl=%h stall=%h bubble=%h, want all 0", c_out_valid, c_out_ctrl, c_stall_cnt, c_bubble_cnt);
    end
    reset_n = 1'b1;
    a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_ctrl = 10'h3FF; a_in_data = DATA_W'(5);
    @(negedge clock);
    a_in_valid = 1'b0;
    checks++;
    if (a_out_valid !== 1'b1 || a_out_ctrl !== 10'h3FF) begin
      errors++; $display("FAIL load_a: valid=%b ctrl=%h, want 1 3ff", a_out_valid, a_out_ctrl);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (a_out_valid !== 1'b0 || a_out_ctrl !== '0 || a_out_data !== '0) begin
      errors++; $display("FAIL async_reset: valid=%b ctrl=%h data=%h, want all 0", a_out_valid, a_out_ctrl, a_out_data);
    end
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    checks++;
    if (a_in_ready !== 1'b1) begin
      errors++; $display("FAIL ready_after_reset: in_ready=%b, want 1", a_in_ready);
    end
  endtask

  task automatic test_streaming();
    logic              ev;
    logic [DATA_W-1:0] ed;
    logic [CTRL_W-1:0] ec;
    @(negedge clock);
    c_out_ready = 1'b1;
    for (int k = 0; k < 15; k++) begin
      c_in_valid = (k < 10);
      c_in_data  = DATA_W'(k + 1);
      c_in_ctrl  = CTRL_W'(k + 1);
      #1;
      ev = (k >= 3) && (k < 13);
      ed = ev ? DATA_W'(k - 2) : '0;
      ec = ev ? CTRL_W'(k - 2) : '0;
      checks++;
      if (c_in_ready !== 1'b1) begin
        errors++; $display("FAIL stream_ready[%0d]: in_ready=%b, want 1", k, c_in_ready);
      end
      checks++;
      if (c_out_valid !== ev || c_out_ctrl !== ec || (ev && c_out_data !== ed)) begin
        errors++; $display("FAIL stream_out[%0d]: valid=%b ctrl=%h data=%h, want %b %h %h", k, c_out_valid, c_out_ctrl, c_out_data, ev, ec, ed);
      end
      @(negedge clock);
    end
    c_in_valid = 1'b0;
  endtask

  task automatic test_stall();
    @(negedge clock);
    b_out_ready = 1'b0;
    b_in_valid = 1'b1; b_in_data = DATA_W'(8'h11); b_in_ctrl = 10'h011;
    @(negedge clock);
    b_in_data = DATA_W'(8'h22); b_in_ctrl = 10'h022;
    @(negedge clock);
    b_in_data = DATA_W'(8'h33); b_in_ctrl = 10'h033;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++;
      if (b_in_ready !== 1'b0 || b_out_valid !== 1'b1 || b_out_data !== DATA_W'(8'h11)) begin
        errors++; $display("FAIL stall_hold[%0d]: in_ready=%b valid=%b data=%h, want 0 1 11", k, b_in_ready, b_out_valid, b_out_data);
      end
      @(negedge clock);
    end
    b_out_ready = 1'b1;
    #1;
    checks++;
    if (b_stall_cnt !== (cnt_en ? 16'd4 : 16'd0)) begin
      errors++; $display("FAIL stall_cnt: got %0d want %0d", b_stall_cnt, cnt_en ? 4 : 0);
    end
    checks++;
    if (b_in_ready !== 1'b1 || b_out_valid !== 1'b1 || b_out_data !== DATA_W'(8'h11)) begin
      errors++; $display("FAIL release_a: in_ready=%b valid=%b data=%h, want 1 1 11", b_in_ready, b_out_valid, b_out_data);
    end
    @(negedge clock);
    b_in_valid = 1'b0;
    #1;
    checks++;
    if (b_out_valid !== 1'b1 || b_out_data !== DATA_W'(8'h22) || b_out_ctrl !== 10'h022) begin
      errors++; $display("FAIL release_b: valid=%b data=%h ctrl=%h, want 1 22 022", b_out_valid, b_out_data, b_out_ctrl);
    end
    @(negedge clock);
    checks++;
    if (b_out_valid !== 1'b1 || b_out_data !== DATA_W'(8'h33)) begin
      errors++; $display("FAIL release_c: valid=%b data=%h, want 1 33", b_out_valid, b_out_data);
    end
    @(negedge clock);
    checks++;
    if (b_out_valid !== 1'b0 || b_out_ctrl !== '0) begin
      errors++; $display("FAIL drained: valid=%b ctrl=%h, want 0 0", b_out_valid, b_out_ctrl);
    end
  endtask

  task automatic test_flush();
    @(negedge clock);
    c_out_ready = 1'b0;
    c_in_ctrl = 10'h155;
    for (int k = 0; k < 3; k++) begin
      c_in_valid = 1'b1;
      c_in_data = DATA_W'(8'hA1 + k);
      @(negedge clock);
    end
    c_out_ready = 1'b1; c_flush = 1'b1; c_in_data = DATA_W'(8'hCC);
    #1;
    checks++;
    if (c_in_ready !== 1'b0) begin
      errors++; $display("FAIL flush_ready: in_ready=%b, want 0", c_in_ready);
    end
    checks++;
    if (c_out_valid !== 1'b1 || c_out_data !== DATA_W'(8'hA1) || c_out_ctrl !== 10'h155) begin
      errors++; $display("FAIL flush_complete: valid=%b data=%h ctrl=%h, want 1 a1 155", c_out_valid, c_out_data, c_out_ctrl);
    end
    @(negedge clock);
    c_flush = 1'b0; c_in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++;
      if (c_out_valid !== 1'b0 || c_out_ctrl !== '0) begin
        errors++; $display("FAIL flush_empty[%0d]: valid=%b ctrl=%h, want 0 0", k, c_out_valid, c_out_ctrl);
      end
      @(negedge clock);
    end
  endtask

  task automatic test_bubble_zeroing();
    int   exp_bub;
    logic ev;
    @(negedge clock);
    reset_n = 1'b0;
    #1 reset_n = 1'b1;
    exp_bub = 0;
    b_out_ready = 1'b1;
    b_in_ctrl = 10'h3FF;
    for (int k = 0; k < 11; k++) begin
      b_in_valid = (k < 8) && (k % 2 == 0);
      b_in_data = DATA_W'(8'h40 + k);
      #1;
      ev = (k >= 2) && (k - 2 < 8) && ((k - 2) % 2 == 0);
      checks++;
      if (b_out_valid !== ev || b_out_ctrl !== (ev ? 10'h3FF : 10'h000) || (ev && b_out_data !== DATA_W'(8'h40 + k - 2))) begin
        errors++; $display("FAIL bubble_out[%0d]: valid=%b ctrl=%h data=%h, want %b", k, b_out_valid, b_out_ctrl, b_out_data, ev);
      end
      checks++;
      if (b_bubble_cnt !== (cnt_en ? 16'(exp_bub) : 16'd0)) begin
        errors++; $display("FAIL bubble_cnt[%0d]: got %0d want %0d", k, b_bubble_cnt, cnt_en ? exp_bub : 0);
      end
      if (!ev) exp_bub++;
      @(negedge clock);
    end
    b_in_valid = 1'b0;
  endtask

  task automatic test_saturation();
    @(negedge clock);
    b_out_ready = 1'b0;
    b_in_valid = 1'b1; b_in_data = DATA_W'(8'h77); b_in_ctrl = 10'h077;
    @(negedge clock);
    b_in_valid = 1'b0;
    repeat (70000) @(posedge clock);
    @(negedge clock);
    checks++;
    if (b_stall_cnt !== 16'hFFFF || b_out_valid !== 1'b1) begin
      errors++; $display("FAIL stall_sat: got %h valid=%b want ffff 1", b_stall_cnt, b_out_valid);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (b_stall_cnt !== 16'h0000) begin
      errors++; $display("FAIL stall_sat_reset: got %h want 0000", b_stall_cnt);
    end
    reset_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_stall();
    test_flush();
    test_bubble_zeroing();
`ifdef STALL_COUNT_EN
    test_saturation();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_stage_elastic.md
Name: pipe_stage_elastic

Overview:
- Parametrised successor to the fixed inter-stage pipeline registers, such as the ID/EX latch.
- Carries one payload bundle (datapath word plus control field) through DEPTH register slots.
- Uses a valid/ready handshake, stall back-pressure and a synchronous flush that inserts bubbles.
- Any empty slot, whether from a bubble or a flush, carries an all-zero control field, so downstream WB/MEM enables can never fire spuriously. Sits between any two core stages (IF/ID, ID/EX, EX/MEM, MEM/WB).

Parameters:
- DATA_W, 138, payload datapath width (pc, readData1, readData2, sign_extended, two 5-bit register fields).
- CTRL_W, 10, control field width (WB, MEM, EXE bundles plus the zero flag).
- DEPTH, 1, number of register slots; legal range 1..8.

Ports:
- clock  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- in_valid  input  1  upstream payload valid
- in_ready  output  1  slot 0 can accept this cycle
- in_data  input  DATA_W  upstream datapath payload
- in_ctrl  input  CTRL_W  upstream control field
- flush  input  1  synchronous squash of all slots
- out_valid  output  1  last slot holds a valid payload
- out_ready  input  1  downstream accepts this cycle
- out_data  output  DATA_W  last-slot datapath payload
- out_ctrl  output  CTRL_W  last-slot control field; all zero whenever out_valid=0
- stall_cnt  output  16  stall cycle counter (STALL_COUNT_EN only)
- bubble_cnt  output  16  bubble cycle counter (STALL_COUNT_EN only)

Behaviour:
- Reset (reset_n=0, asynchronous): every slot's valid, ctrl and data are 0. So out_valid=0, out_data=0, out_ctrl=0, counters=0. Reset mid-transfer discards all contents immediately, with no completion.
- Slot i holds valid[i], ctrl[i], data[i]. Slot DEPTH-1 drives the outputs.
- Advance rules:
  - adv[DEPTH-1] = out_ready or !valid[DEPTH-1].
  - adv[i] = adv[i+1] or !valid[i].
  - in_ready = adv[0] and !flush. Purely combinational from out_ready, valid[] and flush; no registered skid.
- On posedge, for each slot with adv[i]=1:
  - Slot 0 loads in_valid and in_data. It loads in_ctrl if in_valid, else ctrl=0.
  - Slot i>0 loads slot i-1's contents.
  - A slot whose source is invalid gets valid=0 and ctrl=0. Data in that slot is don't-care but holds its last value (no toggle).
- A slot with adv[i]=0 holds all fields.
- Handshakes:
  - Input transfer occurs when in_valid and in_ready.
  - Output transfer occurs when out_valid and out_ready.
  - Upstream must hold in_data/in_ctrl stable while in_valid=1 and in_ready=0.
- Latency and throughput: DEPTH cycles from input transfer to out_valid, with no stall. One payload per cycle sustained.
- Stall: out_ready=0 with all slots valid makes in_ready=0 in the same cycle. Nothing is lost or duplicated. Internal bubbles compress: an upstream slot may advance into an empty downstream slot during a stall.
- Flush (synchronous):
  - At posedge with flush=1, all valid[] and ctrl[] clear to 0 and data holds.
  - The input is not taken (in_ready=0).
  - out_valid is 0 from the next cycle.
  - A same-cycle output transfer (out_valid and out_ready) still completes. The downstream takes that payload.
- Priority: reset_n > flush > advance/hold.
- Ordering: strict FIFO; payloads never reorder.

Optional Feature:
- Macro: STALL_COUNT_EN.
- Defined:
  - stall_cnt increments on every cycle with out_valid=1 and out_ready=0.
  - bubble_cnt increments on every cycle with out_valid=0 and reset_n=1.
  - Both are 16-bit and saturate at 16'hFFFF.
  - Both clear on reset only; flush does not clear them.
- Undefined: the counter logic is absent, and stall_cnt/bubble_cnt are tied to 16'h0000.

Test Plan:
- Reset/idle: DEPTH=1; assert reset_n=0 mid-stream with slot holding ctrl=10'h3FF -> out_valid=0 and out_ctrl=0 asynchronously, before the next edge; in_ready=1 after release.
- Streaming: DEPTH=3, out_ready=1, push payloads data=1..10 on consecutive cycles -> first out_valid 3 cycles after the first transfer; outputs 1..10 in order on consecutive cycles; in_ready stays 1.
- Stall:
  - DEPTH=2; fill with A=0x11, B=0x22; hold out_ready=0 for 4 cycles -> in_ready=0, out_data=0x11 stable, stall_cnt=4 (STALL_COUNT_EN).
  - Release out_ready -> A then B then next input, no loss or duplication.
- Flush:
  - DEPTH=3, full with ctrl=10'h155; pulse flush with out_ready=1 and in_valid=1 carrying C -> the current output completes; C is not accepted.
  - Next cycle: out_valid=0, out_ctrl=0; the following 3 cycles also show out_valid=0 unless new inputs arrive.
- Bubble zeroing: DEPTH=2; alternate in_valid 1/0 with in_ctrl=10'h3FF on both -> out_ctrl=10'h3FF only on valid cycles and 0 on bubble cycles; bubble_cnt counts the bubbles.
- Saturation (STALL_COUNT_EN): hold out_valid=1, out_ready=0 for 70000 cycles -> stall_cnt=16'hFFFF and stays there; a reset pulse then returns it to 0.
